// File: rtl/ccsds123_pkg.sv
// rtl/ccsds123_pkg.sv - shared types and sizing helpers for the ccsds123 receive-side blocks
//
// Contents:
//   ser_state_t       serializer state (IDLE: no word held, SEND: word held, bytes going out)
//   bytes_per_word()  bytes in one BUS_WIDTH-bit compressed word (BYTES_PER_WORD)
//   fifo_level_width() width of a level counter able to hold 0..depth inclusive

package ccsds123_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

    function automatic int bytes_per_word(input int bus_width);
        return bus_width / 8;
    endfunction

    // One extra bit so a completely full FIFO (level == depth) is representable.
    function automatic int fifo_level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ccsds123_sync_fifo.sv
// rtl/ccsds123_sync_fifo.sv - single-clock word FIFO with registered read data
//
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   push, push_data  write request and word; ignored when full unless a pop happens in the same cycle
//   pop              read request; ignored when empty
//   rd_data          popped word, registered: valid after the edge that performs the pop
//   full, empty      occupancy flags derived from the level counter
//   level            number of words currently stored

module ccsds123_sync_fifo
    import ccsds123_pkg::*;
#(
    parameter int WIDTH = 65,
    parameter int DEPTH = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                push,
    input  logic [WIDTH-1:0]                    push_data,
    input  logic                                pop,
    output logic [WIDTH-1:0]                    rd_data,
    output logic                                full,
    output logic                                empty,
    output logic [fifo_level_width(DEPTH)-1:0]  level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = fifo_level_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == LW'(DEPTH));
    assign level   = count;

    // A pop frees the slot the push lands in, so a full FIFO still accepts
    // a word in a cycle where it is also being read.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ccsds123_byte_sink.sv
// rtl/ccsds123_byte_sink.sv - absorbs packed compressor words and re-emits them as a byte stream
//
// Ports:
//   clk, reset                       rising-edge clock, synchronous active-high reset
//   in_tdata, in_tvalid, in_tlast    compressed words, no backpressure
//   out_tdata, out_tvalid,
//   out_tready, out_tlast            byte stream, byte 0 of a word is in_tdata[7:0]
//   overflow                         sticky, set when a word is dropped on a full FIFO
//   fifo_level                       words stored in the FIFO (the word being serialized excluded)

module ccsds123_byte_sink
    import ccsds123_pkg::*;
#(
    parameter int BUS_WIDTH  = 64,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [BUS_WIDTH-1:0]                      in_tdata,
    input  logic                                      in_tvalid,
    input  logic                                      in_tlast,
    output logic [7:0]                                out_tdata,
    output logic                                      out_tvalid,
    input  logic                                      out_tready,
    output logic                                      out_tlast,
    output logic                                      overflow,
    output logic [fifo_level_width(FIFO_DEPTH)-1:0]   fifo_level
);

    localparam int            BYTES_PER_WORD = bytes_per_word(BUS_WIDTH);
    localparam int            IW             = $clog2(BYTES_PER_WORD);
    localparam logic [IW-1:0] LAST_IDX       = IW'(BYTES_PER_WORD - 1);

    logic [BUS_WIDTH:0] fifo_rd_data;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;

    ser_state_t         state_q;
    logic [IW-1:0]      idx_q;
    logic               fetch_q;
    logic               overflow_q;

    logic               sending;
    logic               handshake;
    logic               final_hs;
    logic [7:0]         byte_sel;

    assign sending   = (state_q == SEND);
    assign handshake = sending && out_tready;
    assign final_hs  = handshake && (idx_q == LAST_IDX);

    // Pop when idle (and no fetch already in flight), or on the last byte of
    // the current word so the next word follows without a bubble.
    assign fifo_pop  = !fifo_empty && ((!sending && !fetch_q) || final_hs);

    // The FIFO's registered read port doubles as the serializer holding
    // register: it only changes on a pop, so data is stable during stalls.
    ccsds123_sync_fifo #(
        .WIDTH (BUS_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (in_tvalid),
        .push_data ({in_tlast, in_tdata}),
        .pop       (fifo_pop),
        .rd_data   (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_comb begin
        byte_sel = '0;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (idx_q == IW'(i)) begin
                byte_sel = fifo_rd_data[8*i +: 8];
            end
        end
    end

    assign out_tvalid = sending;
    assign out_tdata  = sending ? byte_sel : 8'h00;
    assign out_tlast  = sending && fifo_rd_data[BUS_WIDTH] && (idx_q == LAST_IDX);
    assign overflow   = overflow_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (in_tvalid && fifo_full && !fifo_pop) begin
            overflow_q <= 1'b1;
        end
    end

    // Idle path: the pop edge registers the word, fetch_q marks it landed,
    // and the following edge enters SEND (first byte two edges after the push).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            fetch_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fetch_q) begin
                        state_q <= SEND;
                        idx_q   <= '0;
                        fetch_q <= 1'b0;
                    end else if (!fifo_empty) begin
                        fetch_q <= 1'b1;
                    end
                end
                SEND: begin
                    if (handshake) begin
                        if (idx_q != LAST_IDX) begin
                            idx_q <= idx_q + IW'(1);
                        end else if (!fifo_empty) begin
                            idx_q <= '0;
                        end else begin
                            state_q <= IDLE;
                            idx_q   <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    idx_q   <= '0;
                    fetch_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ccsds123_byte_sink.md
# ccsds123_byte_sink

Receive-side companion of `ccsds123_top`: absorbs the compressor's packed output stream (`BUS_WIDTH`-bit words, valid/last, no backpressure) into a word FIFO and re-emits it as a byte-wide AXI-Stream with full ready/valid handshaking. It sits between `ccsds123_top` and any byte-oriented consumer: DMA, UART bridge or file-capture bench.
- Byte order matches the compressed file format: byte 0 of each word is `in_tdata[7:0]`.
- FIFO overflow is flagged, never silently hidden.

## Interface
Parameters:
- `BUS_WIDTH`, 64: input word width. Multiple of 8, ≥ 16.
- `FIFO_DEPTH`, 16: word FIFO depth. Power of two, ≥ 2.

Ports:
- `clk`  in  1  single clock, all logic rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_tdata`  in  `BUS_WIDTH`  compressed word from `ccsds123_top.out_tdata`.
- `in_tvalid`  in  1  word present. No ready is returned.
- `in_tlast`  in  1  final word of a compressed image.
- `out_tdata`  out  8  byte stream.
- `out_tvalid`  out  1  byte valid.
- `out_tready`  in  1  consumer ready.
- `out_tlast`  out  1  last byte of an image.
- `overflow`  out  1  sticky: a word was dropped because the FIFO was full.
- `fifo_level`  out  `$clog2(FIFO_DEPTH)+1`  words currently stored in the FIFO, excluding the word held in the serializer.

## Operation
Write side:
- Every cycle with `in_tvalid`=1, `{in_tlast, in_tdata}` is pushed into the FIFO.
- If the FIFO is full and no pop occurs in the same cycle, the word is dropped and `overflow` is set. `overflow` clears only on `reset`.
- Push into a full FIFO in the same cycle as a pop is accepted; the level is unchanged.

Serializer, two states:
- `IDLE`: no word held. If the FIFO is non-empty, pop one word into the holding register, set byte index `idx`=0 and go to `SEND`.
- `SEND`:
  - `out_tdata` = `word[8*idx +: 8]`.
  - `out_tvalid`=1.
  - `out_tlast` = `last_flag && idx == BUS_WIDTH/8-1`.
  - On handshake (`out_tvalid && out_tready`) with `idx` < `BUS_WIDTH/8-1`: `idx` increments.
  - On handshake of the final byte: if the FIFO is non-empty, pop the next word in the same cycle, set `idx`=0 and stay in `SEND`, so there is no bubble between words. Otherwise go to `IDLE`.

General rules:
- While `out_tvalid`=1 and `out_tready`=0, `out_tdata` and `out_tlast` hold stable.
- All bytes of every word are emitted, including pad bytes in the final word. No trimming.
- Several images back to back are supported. `out_tlast` marks each image end, and the next image's bytes follow immediately.

## Timing
- Reset values: `out_tvalid`=0, `out_tlast`=0, `out_tdata`=0, `overflow`=0, `fifo_level`=0. FIFO pointers, `idx` and state (`IDLE`) are all cleared.
- Reset mid-operation discards the FIFO contents and any partially sent word. The first byte after reset is byte 0 of the next word pushed.
- Latency: a word pushed at edge t into an empty, idle block gives `out_tvalid`=1 after edge t+2. The FIFO read is registered, then the holding register loads.
- `fifo_level` updates one cycle after the push/pop edge.
- Throughput: 1 byte per cycle while `out_tready`=1. The producer's sustained rate must not exceed 1 word per `BUS_WIDTH/8` cycles; bursts up to `FIFO_DEPTH`+1 words are absorbed.

## Structure
- Shared package `ccsds123_pkg`:
  - `BYTES_PER_WORD` = `BUS_WIDTH/8`.
  - Serializer state enum `{IDLE, SEND}`.
  - FIFO level width function.
- Sub-module `ccsds123_sync_fifo`:
  - Parameters `WIDTH` = `BUS_WIDTH+1` and `DEPTH`.
  - Ports: push, pop, full, empty, level, registered read data.
  - Synchronous active-high reset.
  - This FIFO is reusable for the input side of `ccsds123_top`.
- Top level holds the serializer FSM, `idx` counter and overflow flag.

## Test plan
1. Single word, `BUS_WIDTH`=64, `in_tdata`=0x0807060504030201, `in_tlast`=1, `out_tready`=1 → bytes 01..08 on consecutive cycles starting at t+2; `out_tlast` only on 08.
2. Three back-to-back words with `out_tready`=1 → 24 contiguous bytes with no bubble between words; `fifo_level` peaks at 2 then drains to 0.
3. `out_tready` toggled randomly (≈1/3 high) across a 100-word image → byte sequence identical to the input little-endian byte dump; data stable during every stall; exactly one `out_tlast`.
4. `out_tready`=0 and 18 words pushed with `FIFO_DEPTH`=16 → 17 words retained (16 in FIFO, 1 in serializer); `overflow`=1 from the 18th push onward; the retained words drain in order once ready rises.
5. Push into a full FIFO in the same cycle as a final-byte pop → word accepted, `overflow` stays 0, `fifo_level` unchanged.
6. `reset` asserted for 1 cycle during byte 3 of a word with 4 words queued → next cycle `out_tvalid`=0, `fifo_level`=0, `overflow`=0; the next pushed word 0xAA.. emits 0xAA as its first byte.
